// File: rtl/esfa_pkg.sv
// esfa_pkg
// Shared definitions for the ESFA result reporter: frame length, default
// frame header, the reporter FSM state type and the frame checksum helper.
package esfa_pkg;

  localparam int         FRAME_LEN            = 8;
  localparam logic [7:0] FRAME_HEADER_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } esfa_state_t;

  // XOR of frame bytes 1..6 (status, error ID, four count bytes).
  // The header is deliberately left out of the checksum.
  function automatic logic [7:0] frame_checksum(
    input logic        ok,
    input logic [7:0]  err_id,
    input logic [31:0] count
  );
    return {7'b0, ok} ^ err_id ^ count[31:24] ^ count[23:16] ^ count[15:8] ^ count[7:0];
  endfunction

endpackage

// File: rtl/esfa_uart_tx_byte.sv
// esfa_uart_tx_byte
// UART 8N1 byte serializer with a registered, glitch-free output.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-low reset
//   i_start  in   load i_data and begin a byte (honoured only when idle)
//   i_data   in   byte to send, LSB first
//   o_done   out  one-cycle pulse near the end of the stop bit
//   o_tx     out  serial line, idle high
module esfa_uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_done,
  output logic       o_tx
);

  localparam int              CNT_W       = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HANDOFF_CNT = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       STOP_BIT    = 4'd9;

  logic             r_active;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [3:0]       r_bit_idx;
  logic [9:0]       r_shift;
  logic             r_tx;

  logic w_bit_end;
  logic w_done;

  assign w_bit_end = (r_clk_cnt == LAST_CNT);

  // The serializer releases itself one cycle before the stop bit ends. The
  // line is already high and stays high for that final cycle, which gives the
  // controller exactly one cycle to present the next byte so its start bit
  // follows the stop bit with no idle gap.
  assign w_done = r_active && (r_bit_idx == STOP_BIT) && (r_clk_cnt == HANDOFF_CNT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_active  <= 1'b0;
      r_clk_cnt <= '0;
      r_bit_idx <= 4'd0;
      r_shift   <= '1;
      r_tx      <= 1'b1;
    end else if (!r_active) begin
      if (i_start) begin
        r_active  <= 1'b1;
        r_clk_cnt <= '0;
        r_bit_idx <= 4'd0;
        r_shift   <= {1'b1, i_data, 1'b0};
        r_tx      <= 1'b0;
      end
    end else if (w_done) begin
      r_active  <= 1'b0;
      r_clk_cnt <= '0;
      r_bit_idx <= 4'd0;
    end else if (w_bit_end) begin
      r_clk_cnt <= '0;
      r_bit_idx <= r_bit_idx + 4'd1;
      r_shift   <= {1'b1, r_shift[9:1]};
      r_tx      <= r_shift[1];
    end else begin
      r_clk_cnt <= r_clk_cnt + CNT_W'(1);
    end
  end

  assign o_done = w_done;
  assign o_tx   = r_tx;

endmodule

// File: rtl/esfa_result_reporter.sv
// esfa_result_reporter
// Measures benchmark run length and, when the run finishes, sends one 8-byte
// result frame (header, status, error ID, 32-bit count MSB first, checksum)
// over a UART 8N1 line.
// Ports:
//   clk                 in   clock, rising edge
//   reset               in   synchronous active-low reset
//   isRunning           in   benchmark executing (counts cycles)
//   wasSuccessful       in   pass flag, captured at trigger
//   instructionOfError  in   failing instruction ID, captured at trigger
//   didRun              in   benchmark finished; rising level triggers report
//   uart_tx             out  serial line, idle high
//   busy                out  frame in flight
//   reportDone          out  frame fully sent, sticky until reset
//   cycleCount          out  live run-length counter (saturating)
module esfa_result_reporter
  import esfa_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] FRAME_HEADER = FRAME_HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isRunning,
  input  logic        wasSuccessful,
  input  logic [7:0]  instructionOfError,
  input  logic        didRun,
  output logic        uart_tx,
  output logic        busy,
  output logic        reportDone,
  output logic [31:0] cycleCount
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  esfa_state_t r_state;
  esfa_state_t w_state_next;

  logic        r_did_run_q;
  logic [31:0] r_cycle_count;
  logic        r_snap_ok;
  logic [7:0]  r_snap_err;
  logic [31:0] r_snap_count;
  logic [2:0]  r_byte_idx;
  logic        r_busy;
  logic        r_report_done;

  logic        w_trigger;
  logic        w_count_en;
  logic        w_start;
  logic        w_ser_done;
  logic        w_tx;
  logic [7:0]  w_byte;

  // r_did_run_q clears in reset, so a didRun already high at release still
  // looks like a rising edge on the first active cycle.
  assign w_trigger  = didRun && !r_did_run_q;
  // The trigger cycle itself is not counted: the snapshot and the live
  // counter agree once the report is under way.
  assign w_count_en = isRunning && (r_state == IDLE) && !w_trigger &&
                      (r_cycle_count != 32'hFFFF_FFFF);

  always_comb begin
    w_byte = FRAME_HEADER;
    case (r_byte_idx)
      3'd0:    w_byte = FRAME_HEADER;
      3'd1:    w_byte = {7'b0, r_snap_ok};
      3'd2:    w_byte = r_snap_err;
      3'd3:    w_byte = r_snap_count[31:24];
      3'd4:    w_byte = r_snap_count[23:16];
      3'd5:    w_byte = r_snap_count[15:8];
      3'd6:    w_byte = r_snap_count[7:0];
      default: w_byte = frame_checksum(r_snap_ok, r_snap_err, r_snap_count);
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      IDLE: if (w_trigger) w_state_next = LOAD;
      LOAD: begin
        w_start      = 1'b1;
        w_state_next = SEND;
      end
      SEND: begin
        if (w_ser_done) begin
          w_state_next = (r_byte_idx == LAST_IDX) ? DONE : LOAD;
        end
      end
      default: w_state_next = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_did_run_q   <= 1'b0;
      r_cycle_count <= '0;
      r_snap_ok     <= 1'b0;
      r_snap_err    <= '0;
      r_snap_count  <= '0;
      r_byte_idx    <= 3'd0;
      r_busy        <= 1'b0;
      r_report_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_did_run_q <= didRun;
      if (w_count_en) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if ((r_state == IDLE) && w_trigger) begin
        r_snap_ok    <= wasSuccessful;
        r_snap_err   <= instructionOfError;
        r_snap_count <= r_cycle_count;
        r_busy       <= 1'b1;
      end
      if ((r_state == SEND) && w_ser_done && (r_byte_idx != LAST_IDX)) begin
        r_byte_idx <= r_byte_idx + 3'd1;
      end
      // DONE is entered during the final (line-high) stop-bit cycle, so
      // busy/reportDone switch one cycle later, right as the stop bit ends.
      if (r_state == DONE) begin
        r_busy        <= 1'b0;
        r_report_done <= 1'b1;
      end
    end
  end

  esfa_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .i_start(w_start),
    .i_data (w_byte),
    .o_done (w_ser_done),
    .o_tx   (w_tx)
  );

  assign uart_tx    = w_tx;
  assign busy       = r_busy;
  assign reportDone = r_report_done;
  assign cycleCount = r_cycle_count;

endmodule

// File: tb/tb_esfa_result_reporter.sv
// tb_esfa_result_reporter
// Randomized and directed runs; every frame is compared, sample by sample,
// against a line waveform built from the frame format and bit timing.
module tb_esfa_result_reporter;

  localparam int CPB     = 4;
  localparam int BYTE_T  = 10 * CPB;
  localparam int FRAME_T = 80 * CPB;
  localparam int CAP     = FRAME_T + 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        isRunning = 1'b0;
  logic        wasSuccessful = 1'b0;
  logic [7:0]  instructionOfError = 8'h00;
  logic        didRun = 1'b0;
  logic        uart_tx;
  logic        busy;
  logic        reportDone;
  logic [31:0] cycleCount;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  esfa_result_reporter #(
    .CLKS_PER_BIT(CPB),
    .FRAME_HEADER(8'hA5)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .isRunning         (isRunning),
    .wasSuccessful     (wasSuccessful),
    .instructionOfError(instructionOfError),
    .didRun            (didRun),
    .uart_tx           (uart_tx),
    .busy              (busy),
    .reportDone        (reportDone),
    .cycleCount        (cycleCount)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One complete report: reset, run, trigger, capture and check the frame.
  // abort_at > 0 pulls reset at that cycle of the frame and checks the line
  // recovers, leaving reset asserted on return.
  task automatic run_frame(input string tag, input int n_run, input bit rand_run,
                           input bit succ, input logic [7:0] ioe,
                           input bit hold_did, input bit sat, input int abort_at);
    logic [31:0] exp_cnt;
    logic [7:0]  exp_bytes [8];
    logic [7:0]  got_bytes [8];
    logic        s_tx   [CAP+1];
    logic        s_busy [CAP+1];
    logic        s_done [CAP+1];
    logic        exp_tx;
    int          err_tx, err_busy, err_done, rd_rise, off, b, p;

    @(negedge clk);
    reset = 1'b0;
    isRunning = 1'b0;
    didRun = hold_did;
    wasSuccessful = succ;
    instructionOfError = ioe;
    repeat (2) @(negedge clk);
    check_val({tag, ".rst_tx"}, 64'(uart_tx), 64'd1);
    check_val({tag, ".rst_busy"}, 64'(busy), 64'd0);
    check_val({tag, ".rst_done"}, 64'(reportDone), 64'd0);
    check_val({tag, ".rst_count"}, 64'(cycleCount), 64'd0);

    reset = 1'b1;
    exp_cnt = 32'd0;
    if (sat) begin
      isRunning = 1'b1;
      force dut.r_cycle_count = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.r_cycle_count;
      exp_cnt = 32'hFFFF_FFFE;
    end
    for (int i = 0; i < n_run; i++) begin
      isRunning = rand_run ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (isRunning && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    end
    isRunning = 1'b0;
    check_val({tag, ".count"}, 64'(cycleCount), 64'(exp_cnt));

    didRun = 1'b1;
    wasSuccessful = succ;
    instructionOfError = ioe;

    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = {7'b0, succ};
    exp_bytes[2] = ioe;
    exp_bytes[3] = exp_cnt[31:24];
    exp_bytes[4] = exp_cnt[23:16];
    exp_bytes[5] = exp_cnt[15:8];
    exp_bytes[6] = exp_cnt[7:0];
    exp_bytes[7] = 8'h00;
    for (int i = 1; i <= 6; i++) exp_bytes[7] = exp_bytes[7] ^ exp_bytes[i];

    // Sample c is the c-th cycle after the trigger edge.
    for (int c = 1; c <= CAP; c++) begin
      @(negedge clk);
      s_tx[c] = uart_tx;
      s_busy[c] = busy;
      s_done[c] = reportDone;
      if (c == abort_at) begin
        reset = 1'b0;
        @(negedge clk);
        check_val({tag, ".abort_tx"}, 64'(uart_tx), 64'd1);
        check_val({tag, ".abort_busy"}, 64'(busy), 64'd0);
        check_val({tag, ".abort_done"}, 64'(reportDone), 64'd0);
        $display("frame %s: reset at cycle %0d, tx=%0b busy=%0b", tag, c, uart_tx, busy);
        return;
      end
    end

    err_tx = 0; err_busy = 0; err_done = 0; rd_rise = 0;
    for (int c = 1; c <= CAP; c++) begin
      exp_tx = 1'b1;
      if (c >= 2 && c < 2 + FRAME_T) begin
        off = c - 2;
        b = off / BYTE_T;
        p = (off % BYTE_T) / CPB;
        if (p == 0) exp_tx = 1'b0;
        else if (p == 9) exp_tx = 1'b1;
        else exp_tx = exp_bytes[b][p-1];
      end
      if (s_tx[c] !== exp_tx) err_tx++;
      if (s_busy[c] !== (c <= FRAME_T + 1)) err_busy++;
      if (s_done[c] !== (c >= FRAME_T + 2)) err_done++;
      if (rd_rise == 0 && s_done[c] === 1'b1) rd_rise = c;
    end

    for (int bi = 0; bi < 8; bi++) begin
      for (int j = 0; j < 8; j++) begin
        got_bytes[bi][j] = s_tx[2 + bi * BYTE_T + (j + 1) * CPB + CPB / 2];
      end
      check_val($sformatf("%s.byte%0d", tag, bi), 64'(got_bytes[bi]), 64'(exp_bytes[bi]));
    end
    check_val({tag, ".line_errs"}, 64'(err_tx), 64'd0);
    check_val({tag, ".busy_errs"}, 64'(err_busy), 64'd0);
    check_val({tag, ".done_errs"}, 64'(err_done), 64'd0);
    check_val({tag, ".done_cycle"}, 64'(rd_rise), 64'(FRAME_T + 2));
    check_val({tag, ".count_held"}, 64'(cycleCount), 64'(exp_cnt));
    $display("frame %s: %02h %02h %02h %02h %02h %02h %02h %02h done@%0d", tag,
             got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3],
             got_bytes[4], got_bytes[5], got_bytes[6], got_bytes[7], rd_rise);
  endtask

  initial begin
    run_frame("pass", 16, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    run_frame("fail", 500, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0, 0);
    run_frame("hold", 0, 1'b0, 1'b1, 8'h5C, 1'b1, 1'b0, 0);
    run_frame("abort", 40, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 2 + 3 * BYTE_T + 5);
    run_frame("fresh", 0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 0);
    run_frame("sat", 5, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 0);
    for (int r = 0; r < 4; r++) begin
      run_frame($sformatf("rand%0d", r), int'($urandom_range(10, 300)), 1'b1,
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/esfa_result_reporter.md
# esfa_result_reporter

Downstream consumer of the ESFA benchmark top-level status outputs (`isRunning`, `wasSuccessful`, `instructionOfError`, `didRun`). It measures run length in clock cycles and, once a run completes, sends one fixed 8-byte result frame over a UART 8N1 transmit line to the host. This makes the pass/fail status, the failing instruction ID and the cycle count observable off-board without an ILA.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud); legal range ≥ 2.
- `FRAME_HEADER`, default 8'hA5: first byte of every frame.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `isRunning`  in  1  benchmark executing.
- `wasSuccessful`  in  1  benchmark pass flag.
- `instructionOfError`  in  8  ID of the first failing instruction.
- `didRun`  in  1  benchmark finished; stays high until reset.
- `uart_tx`  out  1  serial line, idle high.
- `busy`  out  1  frame transmission in progress.
- `reportDone`  out  1  frame fully sent; sticky until reset.
- `cycleCount`  out  32  live run-length counter.

## Operation
- Cycle counter: on each edge with `isRunning`=1 and no report yet triggered, `cycleCount` increments. It saturates at 32'hFFFFFFFF and holds otherwise.
- Trigger: registered `didRun_q` (reset 0). Trigger fires when `didRun`=1 and `didRun_q`=0. If `didRun` is already 1 at reset release, a trigger still fires.
- On trigger, snapshot `wasSuccessful`, `instructionOfError` and the current `cycleCount` register value. The snapshot excludes any increment in the same cycle. Counting then stops.
- Frame bytes, in order:
  - `FRAME_HEADER`
  - `{7'b0, wasSuccessful}`
  - `instructionOfError`
  - count[31:24], count[23:16], count[15:8], count[7:0]
  - checksum = XOR of bytes 1–6
- Each byte is sent as: start bit 0, 8 data bits LSB first, stop bit 1.
- FSM states:
  - IDLE → LOAD on trigger.
  - LOAD → SEND: present byte k to the serializer.
  - SEND → LOAD when the byte completes and k<7; k increments.
  - SEND → DONE when the byte completes and k=7.
  - DONE is terminal until reset.
- Only one report is sent per reset. Later `didRun` edges cannot occur without a reset and are ignored in DONE.
- Reset values: `uart_tx`=1, `busy`=0, `reportDone`=0, `cycleCount`=0, FSM=IDLE, byte index 0.
- Reset mid-frame: on the next edge `uart_tx` returns to 1 and all state clears. The partial frame is abandoned and not resumed.

## Timing
- `uart_tx` is a registered output with no glitches.
- The start bit of byte 0 appears on `uart_tx` 2 cycles after the trigger edge (one for LOAD, one for the serializer register).
- Every bit is exactly `CLKS_PER_BIT` cycles. Bytes are back-to-back with no idle gap: the stop bit of byte k is followed immediately by the start bit of byte k+1.
- Total frame is 80·`CLKS_PER_BIT` cycles.
- `busy`=1 from the cycle after the trigger through the last stop-bit cycle.
- `reportDone` rises on the cycle after the final stop bit completes, in the same cycle `busy` falls.

## Structure
- Shared package `esfa_pkg`:
  - `FRAME_LEN`=8
  - default `FRAME_HEADER`
  - FSM state enum {IDLE, LOAD, SEND, DONE}
- Sub-module `esfa_uart_tx_byte`: byte serializer with a `CLKS_PER_BIT` divider, a 4-bit bit counter, and a `start`/`data[7:0]`/`done` handshake. `start` is honoured only when the serializer is idle; `done` pulses for 1 cycle at the end of the stop bit.
- Top-level: cycle counter, trigger detect, snapshot registers, byte mux, checksum.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Pass run: `isRunning` high for 16 cycles, then `didRun`=1, `wasSuccessful`=1 → frame A5 01 00 00 00 00 10 11 decoded; `reportDone` asserts 322 cycles after the trigger edge.
- Fail run: 500 running cycles, `wasSuccessful`=0, `instructionOfError`=8'h2A → frame A5 00 2A 00 00 01 F4 DF.
- `didRun` held at 1 during reset, then reset released → exactly one frame is sent; `cycleCount`=0 in the frame.
- Reset asserted during byte 3 → `uart_tx`=1 and `busy`=0 on the next edge. After release with `didRun` high, a fresh complete frame is sent.
- Counter saturation: force the counter to 32'hFFFFFFFE, run 5 cycles → it holds 32'hFFFFFFFF; the frame count bytes are FF FF FF FF.
- Line integrity: check every bit width is exactly 4 cycles, there are no gaps between bytes, and `uart_tx`=1 at all times outside the frame.
